// File: rtl/alu_seq.sv
// alu_seq -- registered, valid/ready ALU with carry/overflow/zero flags and an
// optional iterative shift-add multiplier.
//
// Build option: define ALU_MUL_EN to compile in the multi-cycle multiplier
// (MUL state, step counter, accumulator). Without it MUL is a 1-edge op that
// returns 0 with zero=1 and busy is tied low.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operands/op presented
//   in_ready  out  operation accepted this cycle if in_valid (combinational)
//   a, b      in   WIDTH-bit operands
//   op        in   4-bit operation code (OP_* below)
//   out_valid out  output registers hold an unconsumed result
//   out_ready in   consumer takes the result this cycle
//   out       out  WIDTH-bit result
//   flag      out  BEQ taken (a == b)
//   zero      out  result is zero
//   carry     out  ADD/SW/LW carry-out or SUB borrow
//   ovf       out  signed overflow for ADD/SUB
//   busy      out  multiply in progress
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_COM = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LW  = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd10;

  logic [WIDTH-1:0] out_q;
  logic             out_valid_q, flag_q, zero_q, carry_q, ovf_q;

  // Extra MSB captures carry-out of the add and borrow of the subtract.
  logic [WIDTH:0] sum, diff;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  logic [WIDTH-1:0] res_d;
  logic             flag_d, zero_d, carry_d, ovf_d, known_op;

  always_comb begin
    res_d    = '0;
    flag_d   = 1'b0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    known_op = 1'b1;
    case (op)
      OP_ADD, OP_SW, OP_LW: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff[WIDTH-1:0];
        carry_d = diff[WIDTH];
        ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res_d = a & b;
      OP_XOR: res_d = a ^ b;
      // Shift amount is the full unsigned b, so b >= WIDTH yields 0.
      OP_SLL: res_d = a << b;
      OP_SRL: res_d = a >> b;
      OP_COM: res_d = {{(WIDTH-1){1'b0}}, (a <= b)};
      OP_BEQ: flag_d = (a == b);
      OP_MUL: res_d = '0;  // only reaches the outputs when the multiplier is not built
      default: known_op = 1'b0;
    endcase
    // Unknown codes report every flag low, including zero.
    zero_d = known_op && (res_d == '0);
  end

  logic accept, load_alu;
  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_d;
  logic             mul_start, mul_last;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign busy      = (state_q == S_MUL);
  assign mul_start = accept && (op == OP_MUL);
  assign load_alu  = accept && (op != OP_MUL);
  // Only the low WIDTH product bits are kept, so the accumulator stays WIDTH wide.
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last  = (state_q == S_MUL) && (cnt_q == CW'(WIDTH - 1));
`else
  assign in_ready = !out_valid_q || out_ready;
  assign busy     = 1'b0;
  assign load_alu = accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      flag_q      <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
`endif
    end else begin
      if (load_alu) begin
        out_q       <= res_d;
        flag_q      <= flag_d;
        zero_q      <= zero_d;
        carry_q     <= carry_d;
        ovf_q       <= ovf_d;
        out_valid_q <= 1'b1;
      end
`ifdef ALU_MUL_EN
      else if (mul_last) begin
        out_q       <= acc_d;
        flag_q      <= 1'b0;
        zero_q      <= (acc_d == '0);
        carry_q     <= 1'b0;
        ovf_q       <= 1'b0;
        out_valid_q <= 1'b1;
      end
`endif
      else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

`ifdef ALU_MUL_EN
      case (state_q)
        S_IDLE: begin
          if (mul_start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (mul_last) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign flag      = flag_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): table-driven vectors streamed through a
// scoreboard queue, plus hand-written multiply, backpressure and reset cases.
module tb_alu_seq;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_COM = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LW  = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd10;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        flag;
    logic        zero;
    logic        carry;
    logic        ovf;
  } vec_t;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, out;
  logic [3:0]  op;
  logic        flag, zero, carry, ovf, busy;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];
  vec_t tbl[21];

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flag(flag), .zero(zero), .carry(carry), .ovf(ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [15:0] va, input logic [15:0] vb,
                              input logic [15:0] r, input logic f, input logic z,
                              input logic c, input logic v);
    vec_t t;
    t.op = o; t.a = va; t.b = vb; t.out = r;
    t.flag = f; t.zero = z; t.carry = c; t.ovf = v;
    return t;
  endfunction

  // Present one op from the negedge, wait (bounded) for in_ready, then record
  // the expected result. The caller's next negedge follows the accept edge.
  task automatic send(input vec_t v);
    int g;
    @(negedge clk);
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
    #1;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk); #1; g++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(v);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_out"},       {16'd0, out}, 0);
    chk({tag, "_flag"},      {31'd0, flag}, 0);
    chk({tag, "_zero"},      {31'd0, zero}, 0);
    chk({tag, "_carry"},     {31'd0, carry}, 0);
    chk({tag, "_ovf"},       {31'd0, ovf}, 0);
    chk({tag, "_busy"},      {31'd0, busy}, 0);
  endtask

  // Scoreboard monitor: a result transfers on the next posedge when
  // out_valid && out_ready; sample 2 time units before that edge.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", {31'd0, out_valid}, 0);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        $display("txn op=%0d a=%h b=%h out=%h flag=%b zero=%b carry=%b ovf=%b",
                 e.op, e.a, e.b, out, flag, zero, carry, ovf);
        chk($sformatf("op%0d_out", e.op),   {16'd0, out},   {16'd0, e.out});
        chk($sformatf("op%0d_flag", e.op),  {31'd0, flag},  {31'd0, e.flag});
        chk($sformatf("op%0d_zero", e.op),  {31'd0, zero},  {31'd0, e.zero});
        chk($sformatf("op%0d_carry", e.op), {31'd0, carry}, {31'd0, e.carry});
        chk($sformatf("op%0d_ovf", e.op),   {31'd0, ovf},   {31'd0, e.ovf});
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;

    //              op      a         b         out       f  z  c  v
    tbl[0]  = mk(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 0, 1, 1, 0);
    tbl[1]  = mk(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1);
    tbl[2]  = mk(OP_SUB, 16'h0001, 16'h0002, 16'hFFFF, 0, 0, 1, 0);
    tbl[3]  = mk(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 0, 1);
    tbl[4]  = mk(OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0, 0);
    tbl[5]  = mk(OP_XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 0, 0, 0, 0);
    tbl[6]  = mk(OP_SLL, 16'h0001, 16'd20,   16'h0000, 0, 1, 0, 0);
    tbl[7]  = mk(OP_SLL, 16'h0001, 16'd15,   16'h8000, 0, 0, 0, 0);
    tbl[8]  = mk(OP_SLL, 16'h0003, 16'd4,    16'h0030, 0, 0, 0, 0);
    tbl[9]  = mk(OP_SRL, 16'h8000, 16'd15,   16'h0001, 0, 0, 0, 0);
    tbl[10] = mk(OP_SRL, 16'h8000, 16'd16,   16'h0000, 0, 1, 0, 0);
    tbl[11] = mk(OP_COM, 16'h0003, 16'h0003, 16'h0001, 0, 0, 0, 0);
    tbl[12] = mk(OP_COM, 16'h0004, 16'h0003, 16'h0000, 0, 1, 0, 0);
    tbl[13] = mk(OP_COM, 16'h0002, 16'hFFFF, 16'h0001, 0, 0, 0, 0);
    tbl[14] = mk(OP_SW,  16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 0);
    tbl[15] = mk(OP_LW,  16'hFFFE, 16'h0003, 16'h0001, 0, 0, 1, 0);
    tbl[16] = mk(OP_BEQ, 16'h0005, 16'h0005, 16'h0000, 1, 1, 0, 0);
    tbl[17] = mk(OP_BEQ, 16'h0005, 16'h0006, 16'h0000, 0, 1, 0, 0);
    tbl[18] = mk(4'hF,   16'h0001, 16'h0001, 16'h0000, 0, 0, 0, 0);
    tbl[19] = mk(OP_SUB, 16'h0005, 16'h0005, 16'h0000, 0, 1, 0, 0);
`ifdef ALU_MUL_EN
    tbl[20] = mk(OP_MUL, 16'h0003, 16'h0003, 16'h0009, 0, 0, 0, 0);
`else
    tbl[20] = mk(OP_MUL, 16'h0003, 16'h0003, 16'h0000, 0, 1, 0, 0);
`endif

    // Reset state
    #3;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 1);

    // Back-to-back stream with out_ready held high
    for (int i = 0; i < 21; i++) send(tbl[i]);
    @(negedge clk);
    in_valid = 1'b0;
    drain();

`ifdef ALU_MUL_EN
    // Multiply latency: busy high / in_ready low for 16 cycles after accept
    send(mk(OP_MUL, 16'd300, 16'd300, 16'h5F90, 0, 0, 0, 0));
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("mul_busy_c%0d", k),      {31'd0, busy}, 1);
      chk($sformatf("mul_in_ready_c%0d", k),  {31'd0, in_ready}, 0);
      chk($sformatf("mul_out_valid_c%0d", k), {31'd0, out_valid}, 0);
      @(negedge clk);
    end
    #1;
    chk("mul_done_out_valid", {31'd0, out_valid}, 1);
    chk("mul_done_in_ready",  {31'd0, in_ready}, 1);
    chk("mul_done_busy",      {31'd0, busy}, 0);
    drain();
`else
    // Disabled multiplier: single edge, busy never rises
    send(mk(OP_MUL, 16'h0003, 16'h0003, 16'h0000, 0, 1, 0, 0));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mul1_busy",      {31'd0, busy}, 0);
    chk("mul1_out_valid", {31'd0, out_valid}, 1);
    chk("mul1_out",       {16'd0, out}, 0);
    drain();
`endif

    // Backpressure: result held, then a pending XOR accepted on release
    @(negedge clk);
    out_ready = 1'b0;
    send(mk(OP_ADD, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 0));
    @(negedge clk);
    in_valid = 1'b1; op = OP_XOR; a = 16'hF0F0; b = 16'h0FF0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_in_ready_c%0d", k),  {31'd0, in_ready}, 0);
      chk($sformatf("bp_out_c%0d", k),       {16'd0, out}, 32'h0003);
      chk($sformatf("bp_out_valid_c%0d", k), {31'd0, out_valid}, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 1);
    exp_q.push_back(mk(OP_XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 0, 0, 0, 0));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_xor_out",       {16'd0, out}, 32'hFF00);
    chk("bp_xor_out_valid", {31'd0, out_valid}, 1);
    drain();

    // Reset in the middle of an operation: nothing may emerge afterwards
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = OP_MUL; a = 16'd7; b = 16'd9;
    #1;
    chk("rst_mul_accept_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
`ifdef ALU_MUL_EN
    chk("rst_mul_busy_before", {31'd0, busy}, 1);
`else
    chk("rst_mul_pending_before", {31'd0, out_valid}, 1);
`endif
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    for (int k = 0; k < 24; k++) @(negedge clk);
    #1;
    chk("midrst_no_result", {31'd0, out_valid}, 0);
    chk("midrst_no_busy",   {31'd0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
